// File: rtl/priority_event_encoder.sv
// priority_event_encoder: captures rising edges into sticky pending bits and presents the highest unmasked one as a binary code
module priority_event_encoder #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         E,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         ack,
  output logic [W-1:0] code,
  output logic         valid,
  output logic [N-1:0] pending,
  output logic         overrun
);
  typedef enum logic {IDLE, PRESENT} state_t;
  state_t state, state_nxt;
  logic [N-1:0] req_q, rise, clr, cand;
  logic [W-1:0] sel;
  logic hit, load;
  assign rise = req & ~req_q & {N{E}};
  assign clr  = (valid & ack) ? ({{(N-1){1'b0}}, 1'b1} << code) : '0;
  assign cand = pending & ~mask;
  // ascending scan: the last set bit seen is the highest index
  always_comb begin
    sel = '0;
    hit = 1'b0;
    for (int i = 0; i < N; i++)
      if (cand[i]) begin
        sel = W'(i);
        hit = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == IDLE) ? (hit ? PRESENT : IDLE) : (ack ? IDLE : PRESENT);
  always_comb begin
    valid = (state == PRESENT);
    load  = (state == IDLE) & hit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      req_q   <= '0;
      pending <= '0;
      overrun <= 1'b0;
      code    <= '0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clr) | rise;
      overrun <= |(rise & pending & ~clr);
      if (load) code <= sel;
    end
endmodule

// File: tb/tb_priority_event_encoder.sv
// tb_priority_event_encoder: directed and random checks against a behavioural model of the encoder
module tb_priority_event_encoder;
  localparam int N = 8;
  localparam int W = 3;
  logic clk = 1'b0;
  logic rst_n, e, ack;
  logic [N-1:0] req, mask, pending;
  logic [W-1:0] code;
  logic valid, overrun;
  int n_tests = 0;
  int n_fail = 0;

  bit [N-1:0] m_pend, m_reqq;
  bit         m_valid, m_ovr;
  bit [W-1:0] m_code;

  priority_event_encoder #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .E(e), .req(req), .mask(mask), .ack(ack),
    .code(code), .valid(valid), .pending(pending), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0; m_reqq = '0; m_valid = 0; m_ovr = 0; m_code = '0;
  endtask

  // one clock edge of the specified behaviour, from the inputs sampled at that edge
  task automatic model_edge(input bit [N-1:0] r, input bit [N-1:0] m, input bit en, input bit a);
    bit [N-1:0] rise, clr;
    int top;
    rise = '0;
    clr = '0;
    for (int i = 0; i < N; i++) rise[i] = en && r[i] && !m_reqq[i];
    if (m_valid && a) clr[m_code] = 1'b1;
    top = -1;
    for (int i = N - 1; i >= 0; i--)
      if (m_pend[i] && !m[i]) begin
        top = i;
        break;
      end
    m_ovr = |(rise & m_pend & ~clr);
    if (m_valid) begin
      if (a) m_valid = 0;
    end else if (top >= 0) begin
      m_valid = 1;
      m_code = W'(top);
    end
    m_pend = (m_pend & ~clr) | rise;
    m_reqq = r;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".valid"}, 32'(valid), 32'(m_valid));
    check({tag, ".code"}, 32'(code), 32'(m_code));
    check({tag, ".pending"}, 32'(pending), 32'(m_pend));
    check({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
  endtask

  task automatic step(input string tag, input logic [N-1:0] r, input logic [N-1:0] m,
                      input logic en, input logic a);
    req = r; mask = m; e = en; ack = a;
    @(posedge clk);
    model_edge(r, m, en, a);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst_n = 0; e = 1; req = '0; mask = '0; ack = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid", 32'(valid), 0);
    check("rst.code", 32'(code), 0);
    check("rst.pending", 32'(pending), 0);
    check("rst.overrun", 32'(overrun), 0);
    rst_n = 1;

    step("single.idle", 8'h00, 8'h00, 1, 0);
    step("single.cap", 8'h04, 8'h00, 1, 0);
    check("single.pend04", 32'(pending), 32'h04);
    check("single.notyet", 32'(valid), 0);
    step("single.pres", 8'h04, 8'h00, 1, 0);
    check("single.code2", 32'(code), 2);
    check("single.valid", 32'(valid), 1);
    step("single.ack", 8'h04, 8'h00, 1, 1);
    check("single.cleared", 32'(pending), 0);
    check("single.valid0", 32'(valid), 0);

    step("prio.low", 8'h00, 8'h00, 1, 0);
    step("prio.cap", 8'h81, 8'h00, 1, 0);
    step("prio.p7", 8'h81, 8'h00, 1, 0);
    check("prio.code7", 32'(code), 7);
    step("prio.ack7", 8'h81, 8'h00, 1, 1);
    step("prio.p0", 8'h81, 8'h00, 1, 0);
    check("prio.code0", 32'(code), 0);
    step("prio.ack0", 8'h00, 8'h00, 1, 1);
    check("prio.empty", 32'(pending), 0);

    step("mask.cap", 8'h30, 8'h20, 1, 0);
    step("mask.p4", 8'h30, 8'h20, 1, 0);
    check("mask.code4", 32'(code), 4);
    step("mask.hold", 8'hb0, 8'h00, 1, 0);
    check("mask.stable", 32'(code), 4);
    step("mask.ack4", 8'hb0, 8'h00, 1, 1);
    step("mask.p7", 8'hb0, 8'h00, 1, 0);
    check("mask.code7", 32'(code), 7);
    step("mask.ack7", 8'hb0, 8'h00, 1, 1);
    step("mask.p5", 8'h00, 8'h00, 1, 0);
    check("mask.code5", 32'(code), 5);
    step("mask.ack5", 8'h00, 8'h00, 1, 1);

    step("setwin.cap", 8'h08, 8'h00, 1, 0);
    step("setwin.p3", 8'h00, 8'h00, 1, 0);
    check("setwin.code3", 32'(code), 3);
    step("setwin.ackrise", 8'h08, 8'h00, 1, 1);
    check("setwin.kept", 32'(pending), 32'h08);
    check("setwin.noovr", 32'(overrun), 0);
    step("setwin.again", 8'h00, 8'h00, 1, 0);
    check("setwin.re3", 32'(code), 3);
    check("setwin.revalid", 32'(valid), 1);
    step("ovr.edge", 8'h08, 8'h00, 1, 0);
    check("ovr.pulse", 32'(overrun), 1);
    step("ovr.drop", 8'h08, 8'h00, 1, 0);
    check("ovr.oneshot", 32'(overrun), 0);
    step("ovr.ack", 8'h00, 8'h00, 1, 1);

    step("en.low", 8'h00, 8'h00, 0, 0);
    step("en.gated", 8'h10, 8'h00, 0, 0);
    check("en.nocap", 32'(pending), 0);
    step("en.back", 8'h10, 8'h00, 1, 0);
    check("en.lost", 32'(pending), 0);
    step("en.drop", 8'h00, 8'h00, 1, 0);
    step("en.recap", 8'h10, 8'h00, 1, 0);
    check("en.captured", 32'(pending), 32'h10);
    step("en.pres", 8'h10, 8'h00, 1, 0);
    step("en.ack", 8'h00, 8'h00, 1, 1);

    step("ar.cap", 8'h41, 8'h00, 1, 0);
    step("ar.pres", 8'h41, 8'h00, 1, 0);
    check("ar.code6", 32'(code), 6);
    check("ar.pend41", 32'(pending), 32'h41);
    #3;
    rst_n = 0;
    #1;
    model_reset();
    compare_all("ar.async");
    ack = 1;
    @(posedge clk);
    #1;
    compare_all("ar.held");
    rst_n = 1;
    step("ar.rel1", 8'h41, 8'h00, 1, 0);
    check("ar.recap", 32'(pending), 32'h41);
    step("ar.rel2", 8'h41, 8'h00, 1, 0);
    check("ar.code6b", 32'(code), 6);
    check("ar.valid", 32'(valid), 1);

    for (int i = 0; i < 500; i++) begin
      logic [N-1:0] r, m;
      r = N'($urandom) & N'($urandom);
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step("rand", r, m, $urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
